// File: rtl/cpu_mem_arbiter_if.sv
// Memory bus between the core-side arbiter and the shared memory port.
// The master drives requests; the slave answers with grant and response.
interface cpu_mem_arbiter_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [7:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one variable-latency bus between the fetch and load/store ports.
// Data access goes first, then fetch; results replay with SRAM timing.
module cpu_mem_arbiter #(
    parameter int TIMEOUT_CYC = 0,
    parameter bit RESET_PC_RD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [63:0] inst_sram_addr,
    output logic [63:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [7:0]  data_sram_we,
    input  logic [63:0] data_sram_addr,
    input  logic [63:0] data_sram_wdata,
    output logic [63:0] data_sram_rdata,
    output logic        stallreq_axi,
    output logic        bus_err,
    cpu_mem_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT,
        RELEASE
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

    state_t      state_q;
    state_t      state_d;
    logic        inst_req;
    logic        inst_f_q;
    logic        data_f_q;
    logic [63:0] inst_addr_q;
    logic [63:0] data_addr_q;
    logic [63:0] data_wdata_q;
    logic [7:0]  data_we_q;
    logic [63:0] inst_pend_q;
    logic [63:0] data_pend_q;
    logic [63:0] inst_rdata_q;
    logic [63:0] data_rdata_q;
    logic [15:0] cnt_q;
    logic        bus_err_q;
    logic        busy;
    logic        timeout;
    logic        d_done;
    logic        i_done;
    logic        req;
    logic [7:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;

    assign inst_req = inst_sram_en && !(RESET_PC_RD && rst);

    assign busy = (state_q == D_REQ) || (state_q == D_WAIT) ||
                  (state_q == I_REQ) || (state_q == I_WAIT);

    assign timeout = (TIMEOUT_CYC != 0) && busy && (cnt_q == TO_LIM);

    assign d_done = ((state_q == D_REQ) && timeout) ||
                    ((state_q == D_WAIT) && (timeout || bus.mem_rvalid));

    assign i_done = ((state_q == I_REQ) && timeout) ||
                    ((state_q == I_WAIT) && (timeout || bus.mem_rvalid));

    assign stallreq_axi = (state_q == IDLE) ? (inst_req || data_sram_en)
                                            : (state_q != RELEASE);

    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign bus_err         = bus_err_q;

    // Next-state and bus request fields; fields come only from latched state.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    state_d = D_REQ;
                end else if (inst_req) begin
                    state_d = I_REQ;
                end
            end
            D_REQ: begin
                if (timeout) begin
                    state_d = inst_f_q ? I_REQ : RELEASE;
                end else begin
                    req   = 1'b1;
                    we    = data_we_q;
                    addr  = data_addr_q;
                    wdata = data_wdata_q;
                    if (bus.mem_gnt) begin
                        state_d = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (d_done) begin
                    state_d = inst_f_q ? I_REQ : RELEASE;
                end
            end
            I_REQ: begin
                if (timeout) begin
                    state_d = RELEASE;
                end else begin
                    req  = 1'b1;
                    addr = inst_addr_q;
                    if (bus.mem_gnt) begin
                        state_d = I_WAIT;
                    end
                end
            end
            I_WAIT: begin
                if (i_done) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latching, response capture and replay to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_f_q     <= 1'b0;
            data_f_q     <= 1'b0;
            inst_addr_q  <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_we_q    <= '0;
            inst_pend_q  <= '0;
            data_pend_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if ((state_q == IDLE) && (state_d != IDLE)) begin
                inst_f_q     <= inst_req;
                data_f_q     <= data_sram_en;
                inst_addr_q  <= inst_sram_addr;
                data_addr_q  <= data_sram_addr;
                data_wdata_q <= data_sram_wdata;
                data_we_q    <= data_sram_we;
            end
            if (d_done) begin
                data_pend_q <= timeout ? '0 : bus.mem_rdata;
            end
            if (i_done) begin
                inst_pend_q <= timeout ? '0 : bus.mem_rdata;
            end
            if (state_q == RELEASE) begin
                if (inst_f_q) begin
                    inst_rdata_q <= inst_pend_q;
                end
                if (data_f_q && (data_we_q == '0)) begin
                    data_rdata_q <= data_pend_q;
                end
                inst_f_q <= 1'b0;
                data_f_q <= 1'b0;
            end
        end
    end

    // Watchdog: per-state wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

endmodule
